// File: rtl/decode_stage.sv
// decode_stage: registered RV32 decoder between fetch and execute.
// Ports: clk/rst/flush, fetch valid/ready + instr/pc, execute valid/ready + decoded bundle,
//        illegal_count (saturating count of accepted illegal instructions).
module decode_stage #(
   parameter int XLEN      = 32,
   parameter int NUM_REGS  = 32,
   parameter int HAS_M     = 1,
   parameter int ILL_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [XLEN-1:0]      in_pc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_pc,
   output logic [3:0]           out_kind,
   output logic [3:0]           out_alu_op,
   output logic [2:0]           out_branch_op,
   output logic [4:0]           out_rs1,
   output logic [4:0]           out_rs2,
   output logic [4:0]           out_rd,
   output logic                 out_rs1_used,
   output logic                 out_rs2_used,
   output logic                 out_reg_write,
   output logic                 out_mem_read,
   output logic                 out_mem_write,
   output logic [1:0]           out_mem_width,
   output logic                 out_mem_unsigned,
   output logic [XLEN-1:0]      out_imm,
   output logic                 out_illegal,
   output logic [ILL_CNT_W-1:0] illegal_count
);

   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OP_IMM = 5'b00100;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_FENCE  = 5'b00011;

   localparam logic [3:0] K_NOP    = 4'd0;
   localparam logic [3:0] K_OP     = 4'd1;
   localparam logic [3:0] K_OP_IMM = 4'd2;
   localparam logic [3:0] K_LOAD   = 4'd3;
   localparam logic [3:0] K_STORE  = 4'd4;
   localparam logic [3:0] K_BRANCH = 4'd5;
   localparam logic [3:0] K_JAL    = 4'd6;
   localparam logic [3:0] K_JALR   = 4'd7;
   localparam logic [3:0] K_LUI    = 4'd8;
   localparam logic [3:0] K_AUIPC  = 4'd9;
   localparam logic [3:0] K_ILL    = 4'd15;

   localparam logic [3:0] A_ADD  = 4'b0000;
   localparam logic [3:0] A_SUB  = 4'b0001;
   localparam logic [3:0] A_XOR  = 4'b0010;
   localparam logic [3:0] A_OR   = 4'b0011;
   localparam logic [3:0] A_AND  = 4'b0100;
   localparam logic [3:0] A_SLL  = 4'b0101;
   localparam logic [3:0] A_SRL  = 4'b0110;
   localparam logic [3:0] A_SRA  = 4'b1000;
   localparam logic [3:0] A_SLT  = 4'b1001;
   localparam logic [3:0] A_SLTU = 4'b1011;
   localparam logic [3:0] A_MUL  = 4'b1100;
   localparam logic [3:0] A_DIV  = 4'b1101;
   localparam logic [3:0] A_REM  = 4'b1110;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      kind;
      logic [3:0]      alu_op;
      logic [2:0]      branch_op;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rs1_used;
      logic            rs2_used;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [1:0]      mem_width;
      logic            mem_unsigned;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } bundle_t;

   function automatic logic [3:0] f3_alu(input logic [2:0] f);
      logic [3:0] r;
      case (f)
         3'b000:  r = A_ADD;
         3'b001:  r = A_SLL;
         3'b010:  r = A_SLT;
         3'b011:  r = A_SLTU;
         3'b100:  r = A_XOR;
         3'b101:  r = A_SRL;
         3'b110:  r = A_OR;
         default: r = A_AND;
      endcase
      return r;
   endfunction

   logic [4:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [4:0]  rs1_f, rs2_f, rd_f;
   logic        quad_ok;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opc     = in_instr[6:2];
   assign f3      = in_instr[14:12];
   assign f7      = in_instr[31:25];
   assign rs1_f   = in_instr[19:15];
   assign rs2_f   = in_instr[24:20];
   assign rd_f    = in_instr[11:7];
   assign quad_ok = in_instr[1:0] == 2'b11;

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

   logic is_op, is_opi, is_ld, is_st, is_br;
   logic is_jal, is_jalr, is_lui, is_auipc, is_fence;

   assign is_op    = quad_ok && opc == OPC_OP;
   assign is_opi   = quad_ok && opc == OPC_OP_IMM;
   assign is_ld    = quad_ok && opc == OPC_LOAD;
   assign is_st    = quad_ok && opc == OPC_STORE;
   assign is_br    = quad_ok && opc == OPC_BRANCH;
   assign is_jal   = quad_ok && opc == OPC_JAL;
   assign is_jalr  = quad_ok && opc == OPC_JALR;
   assign is_lui   = quad_ok && opc == OPC_LUI;
   assign is_auipc = quad_ok && opc == OPC_AUIPC;
   assign is_fence = quad_ok && opc == OPC_FENCE;

   logic        legal, use1, use2, used, ill;
   logic [3:0]  kind, alu;
   logic [2:0]  bop;
   logic        mr, mw, mu;
   logic [1:0]  mwid;
   logic [31:0] imm32;

   always_comb begin
      legal = 1'b0;
      use1  = 1'b0;
      use2  = 1'b0;
      used  = 1'b0;
      kind  = K_ILL;
      alu   = A_ADD;
      bop   = 3'b000;
      mr    = 1'b0;
      mw    = 1'b0;
      mu    = 1'b0;
      mwid  = 2'b00;
      imm32 = 32'b0;
      unique case (1'b1)
         is_op: begin
            kind = K_OP;
            use1 = 1'b1;
            use2 = 1'b1;
            used = 1'b1;
            case (f7)
               7'b0000000: begin
                  legal = 1'b1;
                  alu   = f3_alu(f3);
               end
               7'b0100000: begin
                  legal = f3 == 3'b000 || f3 == 3'b101;
                  alu   = f3[2] ? A_SRA : A_SUB;
               end
               7'b0000001: begin
                  legal = HAS_M != 0 &&
                          (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b110);
                  alu   = f3 == 3'b000 ? A_MUL :
                          f3 == 3'b100 ? A_DIV : A_REM;
               end
               default: legal = 1'b0;
            endcase
         end
         is_opi: begin
            kind  = K_OP_IMM;
            use1  = 1'b1;
            used  = 1'b1;
            imm32 = imm_i;
            legal = 1'b1;
            alu   = f3_alu(f3);
            // shift-immediates keep funct7 in the upper immediate bits
            if (f3 == 3'b001 && f7 != 7'b0000000) legal = 1'b0;
            if (f3 == 3'b101) begin
               if (f7 == 7'b0100000) alu = A_SRA;
               else if (f7 != 7'b0000000) legal = 1'b0;
            end
         end
         is_ld: begin
            kind  = K_LOAD;
            use1  = 1'b1;
            used  = 1'b1;
            mr    = 1'b1;
            mwid  = f3[1:0];
            mu    = f3[2];
            imm32 = imm_i;
            legal = f3[1:0] != 2'b11 && !(f3[2] && f3[1]);
         end
         is_st: begin
            kind  = K_STORE;
            use1  = 1'b1;
            use2  = 1'b1;
            mw    = 1'b1;
            mwid  = f3[1:0];
            imm32 = imm_s;
            legal = !f3[2] && f3[1:0] != 2'b11;
         end
         is_br: begin
            kind  = K_BRANCH;
            use1  = 1'b1;
            use2  = 1'b1;
            bop   = f3;
            imm32 = imm_b;
            legal = f3[2:1] != 2'b01;
         end
         is_jal: begin
            kind  = K_JAL;
            used  = 1'b1;
            imm32 = imm_j;
            legal = 1'b1;
         end
         is_jalr: begin
            kind  = K_JALR;
            use1  = 1'b1;
            used  = 1'b1;
            imm32 = imm_i;
            legal = f3 == 3'b000;
         end
         is_lui: begin
            kind  = K_LUI;
            used  = 1'b1;
            imm32 = imm_u;
            legal = 1'b1;
         end
         is_auipc: begin
            kind  = K_AUIPC;
            used  = 1'b1;
            imm32 = imm_u;
            legal = 1'b1;
         end
         is_fence: begin
            kind  = K_NOP;
            legal = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // RV32E: only indices actually read or written must fit in x0..x15
   assign ill = !legal || (NUM_REGS == 16 &&
                ((use1 && rs1_f[4]) || (use2 && rs2_f[4]) ||
                 (used && rd_f[4])));

   bundle_t nxt, q;

   always_comb begin
      nxt     = '0;
      nxt.pc  = in_pc;
      nxt.rs1 = rs1_f;
      nxt.rs2 = rs2_f;
      nxt.rd  = rd_f;
      if (ill) begin
         nxt.kind    = K_ILL;
         nxt.illegal = 1'b1;
      end else begin
         nxt.kind         = kind;
         nxt.alu_op       = alu;
         nxt.branch_op    = bop;
         nxt.rs1          = use1 ? rs1_f : 5'd0;
         nxt.rs2          = use2 ? rs2_f : 5'd0;
         nxt.rd           = used ? rd_f : 5'd0;
         nxt.rs1_used     = use1;
         nxt.rs2_used     = use2;
         nxt.reg_write    = used && rd_f != 5'd0;
         nxt.mem_read     = mr;
         nxt.mem_write    = mw;
         nxt.mem_width    = mwid;
         nxt.mem_unsigned = mu;
         nxt.imm          = XLEN'($signed(imm32));
      end
   end

   logic                 valid_q;
   logic [ILL_CNT_W-1:0] cnt_q;
   logic                 accept;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         q       <= nxt;
         valid_q <= 1'b1;
         if (nxt.illegal && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid        = valid_q;
   assign out_pc           = q.pc;
   assign out_kind         = q.kind;
   assign out_alu_op       = q.alu_op;
   assign out_branch_op    = q.branch_op;
   assign out_rs1          = q.rs1;
   assign out_rs2          = q.rs2;
   assign out_rd           = q.rd;
   assign out_rs1_used     = q.rs1_used;
   assign out_rs2_used     = q.rs2_used;
   assign out_reg_write    = q.reg_write;
   assign out_mem_read     = q.mem_read;
   assign out_mem_write    = q.mem_write;
   assign out_mem_width    = q.mem_width;
   assign out_mem_unsigned = q.mem_unsigned;
   assign out_imm          = q.imm;
   assign out_illegal      = q.illegal;
   assign illegal_count    = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table + scoreboard for the default build,
// directed sequences for an RV32E / no-M / 2-bit-counter build.
module tb_decode_stage;

   typedef struct packed {
      logic [3:0]  kind;
      logic [3:0]  alu;
      logic [2:0]  bop;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        r1u;
      logic        r2u;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [1:0]  w;
      logic        un;
      logic [31:0] imm;
      logic        ill;
   } dec_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      dec_t        exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [3:0]  out_kind, out_alu_op;
   logic [2:0]  out_branch_op;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_rs1_used, out_rs2_used, out_reg_write;
   logic        out_mem_read, out_mem_write, out_mem_unsigned, out_illegal;
   logic [1:0]  out_mem_width;
   logic [15:0] illegal_count;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_kind(out_kind), .out_alu_op(out_alu_op),
      .out_branch_op(out_branch_op),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
      .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_width(out_mem_width), .out_mem_unsigned(out_mem_unsigned),
      .out_imm(out_imm), .out_illegal(out_illegal),
      .illegal_count(illegal_count)
   );

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_imm;
   logic [3:0]  b_out_kind, b_out_alu_op;
   logic [2:0]  b_out_branch_op;
   logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
   logic        b_out_rs1_used, b_out_rs2_used, b_out_reg_write;
   logic        b_out_mem_read, b_out_mem_write, b_out_mem_unsigned;
   logic        b_out_illegal;
   logic [1:0]  b_out_mem_width;
   logic [1:0]  b_cnt;

   decode_stage #(.XLEN(32), .NUM_REGS(16), .HAS_M(0), .ILL_CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_instr(b_in_instr), .in_pc(b_in_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_pc(b_out_pc), .out_kind(b_out_kind), .out_alu_op(b_out_alu_op),
      .out_branch_op(b_out_branch_op),
      .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd),
      .out_rs1_used(b_out_rs1_used), .out_rs2_used(b_out_rs2_used),
      .out_reg_write(b_out_reg_write),
      .out_mem_read(b_out_mem_read), .out_mem_write(b_out_mem_write),
      .out_mem_width(b_out_mem_width),
      .out_mem_unsigned(b_out_mem_unsigned),
      .out_imm(b_out_imm), .out_illegal(b_out_illegal),
      .illegal_count(b_cnt)
   );

   int checks = 0;
   int failures = 0;

   dec_t        exp_q[$];
   logic [31:0] pc_q[$];
   logic        m_valid = 1'b0;
   logic [15:0] m_cnt = 16'd0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // flags = {rs1_used, rs2_used, reg_write, mem_read, mem_write}
   function automatic dec_t ok(input logic [3:0] k, input logic [3:0] a,
                               input logic [2:0] b, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] d,
                               input logic [4:0] fl, input logic [2:0] wu,
                               input logic [31:0] imm);
      return '{k, a, b, r1, r2, d, fl[4], fl[3], fl[2], fl[1], fl[0],
               wu[2:1], wu[0], imm, 1'b0};
   endfunction

   function automatic dec_t ill(input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] d);
      return '{4'hF, 4'h0, 3'h0, r1, r2, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               2'b00, 1'b0, 32'h0, 1'b1};
   endfunction

   function automatic dec_t dut_dec();
      return '{out_kind, out_alu_op, out_branch_op, out_rs1, out_rs2, out_rd,
               out_rs1_used, out_rs2_used, out_reg_write, out_mem_read,
               out_mem_write, out_mem_width, out_mem_unsigned, out_imm,
               out_illegal};
   endfunction

   function automatic dec_t b_dec();
      return '{b_out_kind, b_out_alu_op, b_out_branch_op, b_out_rs1,
               b_out_rs2, b_out_rd, b_out_rs1_used, b_out_rs2_used,
               b_out_reg_write, b_out_mem_read, b_out_mem_write,
               b_out_mem_width, b_out_mem_unsigned, b_out_imm,
               b_out_illegal};
   endfunction

   // one clock of the default build: compare what is presented, update model
   task automatic cycle(input logic v, input logic [31:0] ins,
                        input logic [31:0] pc, input dec_t e,
                        input logic rdy, input logic fl);
      logic acc, cons;
      in_valid  = v;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      #1;
      chk("out_valid", 128'(out_valid), 128'(m_valid));
      chk("in_ready", 128'(in_ready), 128'(!m_valid || rdy));
      chk("illegal_count", 128'(illegal_count), 128'(m_cnt));
      if (m_valid) begin
         chk("bundle", 128'(dut_dec()), 128'(exp_q[0]));
         chk("out_pc", 128'(out_pc), 128'(pc_q[0]));
      end
      cons = m_valid && rdy;
      acc  = v && (!m_valid || rdy) && !fl;
      if (m_valid && (cons || fl)) begin
         void'(exp_q.pop_front());
         void'(pc_q.pop_front());
      end
      if (acc) begin
         exp_q.push_back(e);
         pc_q.push_back(pc);
         if (e.ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      m_valid = !fl && (acc || (m_valid && !rdy));
      @(posedge clk);
      #1;
   endtask

   task automatic b_issue(input string nm, input logic [31:0] ins,
                          input logic fl, input dec_t e, input logic ev,
                          input logic [1:0] ecnt);
      b_in_valid  = 1'b1;
      b_in_instr  = ins;
      b_in_pc     = 32'h2000;
      b_flush     = fl;
      b_out_ready = 1'b1;
      #1;
      chk({nm, " in_ready"}, 128'(b_in_ready), 128'(1'b1));
      @(posedge clk);
      #1;
      b_in_valid = 1'b0;
      b_flush    = 1'b0;
      chk({nm, " valid"}, 128'(b_out_valid), 128'(ev));
      chk({nm, " count"}, 128'(b_cnt), 128'(ecnt));
      if (ev) begin
         chk(nm, 128'(b_dec()), 128'(e));
         chk({nm, " pc"}, 128'(b_out_pc), 128'(32'h2000));
      end
   endtask

   vec_t vt[$];
   dec_t z;

   initial begin
      z = '0;
      vt.push_back('{"addi", 32'hFFF00093, ok(4'd2, 4'h0, 3'd0, 5'd0, 5'd0,
                     5'd1, 5'b10100, 3'b000, 32'hFFFFFFFF)});
      vt.push_back('{"jal", 32'h008000EF, ok(4'd6, 4'h0, 3'd0, 5'd0, 5'd0,
                     5'd1, 5'b00100, 3'b000, 32'h8)});
      vt.push_back('{"srai", 32'h40315113, ok(4'd2, 4'h8, 3'd0, 5'd2, 5'd0,
                     5'd2, 5'b10100, 3'b000, 32'h403)});
      vt.push_back('{"srai_f7", 32'h42315113, ill(5'd2, 5'd3, 5'd2)});
      vt.push_back('{"mul", 32'h022081B3, ok(4'd1, 4'hC, 3'd0, 5'd1, 5'd2,
                     5'd3, 5'b11100, 3'b000, 32'h0)});
      vt.push_back('{"add_x0", 32'h00208033, ok(4'd1, 4'h0, 3'd0, 5'd1,
                     5'd2, 5'd0, 5'b11000, 3'b000, 32'h0)});
      vt.push_back('{"lw", 32'hFFC32283, ok(4'd3, 4'h0, 3'd0, 5'd6, 5'd0,
                     5'd5, 5'b10110, 3'b100, 32'hFFFFFFFC)});
      vt.push_back('{"lbu", 32'h00144383, ok(4'd3, 4'h0, 3'd0, 5'd8, 5'd0,
                     5'd7, 5'b10110, 3'b001, 32'h1)});
      vt.push_back('{"sw", 32'h00952423, ok(4'd4, 4'h0, 3'd0, 5'd10, 5'd9,
                     5'd0, 5'b11001, 3'b100, 32'h8)});
      vt.push_back('{"bne", 32'hFE209EE3, ok(4'd5, 4'h0, 3'd1, 5'd1, 5'd2,
                     5'd0, 5'b11000, 3'b000, 32'hFFFFFFFC)});
      vt.push_back('{"br_f3_010", 32'hFE20AEE3, ill(5'd1, 5'd2, 5'd29)});
      vt.push_back('{"lui", 32'h123452B7, ok(4'd8, 4'h0, 3'd0, 5'd0, 5'd0,
                     5'd5, 5'b00100, 3'b000, 32'h12345000)});
      vt.push_back('{"auipc", 32'hFFFFF317, ok(4'd9, 4'h0, 3'd0, 5'd0, 5'd0,
                     5'd6, 5'b00100, 3'b000, 32'hFFFFF000)});
      vt.push_back('{"jalr", 32'h00C280E7, ok(4'd7, 4'h0, 3'd0, 5'd5, 5'd0,
                     5'd1, 5'b10100, 3'b000, 32'hC)});
      vt.push_back('{"fence", 32'h0FF0000F, ok(4'd0, 4'h0, 3'd0, 5'd0, 5'd0,
                     5'd0, 5'b00000, 3'b000, 32'h0)});
      vt.push_back('{"bad_quad", 32'h00208032, ill(5'd1, 5'd2, 5'd0)});
      vt.push_back('{"sub", 32'h40628233, ok(4'd1, 4'h1, 3'd0, 5'd5, 5'd6,
                     5'd4, 5'b11100, 3'b000, 32'h0)});
      vt.push_back('{"slli_f7", 32'h40111093, ill(5'd2, 5'd1, 5'd1)});
      vt.push_back('{"div", 32'h023140B3, ok(4'd1, 4'hD, 3'd0, 5'd2, 5'd3,
                     5'd1, 5'b11100, 3'b000, 32'h0)});
      vt.push_back('{"mulh", 32'h023110B3, ill(5'd2, 5'd3, 5'd1)});
      vt.push_back('{"sltiu", 32'h00513093, ok(4'd2, 4'hB, 3'd0, 5'd2, 5'd0,
                     5'd1, 5'b10100, 3'b000, 32'h5)});

      rst = 1'b1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      b_in_instr = 32'h0; b_in_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst out_valid", 128'(out_valid), 128'(1'b0));
      chk("rst in_ready", 128'(in_ready), 128'(1'b1));
      chk("rst bundle", 128'(dut_dec()), 128'(z));
      chk("rst out_pc", 128'(out_pc), 128'(32'h0));
      chk("rst count", 128'(illegal_count), 128'(16'h0));
      chk("rst b valid", 128'(b_out_valid), 128'(1'b0));
      chk("rst b count", 128'(b_cnt), 128'(2'b00));

      // full-throughput table
      foreach (vt[i])
         cycle(1'b1, vt[i].instr, 32'h1000 + 32'(4 * i), vt[i].exp,
               1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, z, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, z, 1'b1, 1'b0);
      chk("table ill count", 128'(illegal_count), 128'(16'd5));

      // backpressure: second instruction waits, first held stable
      cycle(1'b1, vt[0].instr, 32'h3000, vt[0].exp, 1'b0, 1'b0);
      cycle(1'b1, vt[8].instr, 32'h3004, vt[8].exp, 1'b0, 1'b0);
      cycle(1'b1, vt[8].instr, 32'h3004, vt[8].exp, 1'b0, 1'b0);
      cycle(1'b1, vt[8].instr, 32'h3004, vt[8].exp, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, z, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, z, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, z, 1'b1, 1'b0);
      chk("bp queue empty", 128'(exp_q.size()), 128'(0));

      // flush drops held bundle and the offered illegal one
      cycle(1'b1, vt[11].instr, 32'h4000, vt[11].exp, 1'b0, 1'b0);
      cycle(1'b1, vt[15].instr, 32'h4004, vt[15].exp, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 32'h0, z, 1'b1, 1'b0);

      // reset mid-stream beats accept
      cycle(1'b1, vt[11].instr, 32'h5000, vt[11].exp, 1'b1, 1'b0);
      in_valid = 1'b1; in_instr = vt[15].instr; out_ready = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      m_valid = 1'b0; m_cnt = 16'd0;
      exp_q.delete(); pc_q.delete();
      chk("midrst valid", 128'(out_valid), 128'(1'b0));
      chk("midrst count", 128'(illegal_count), 128'(16'd0));
      chk("midrst bundle", 128'(dut_dec()), 128'(z));
      cycle(1'b0, 32'h0, 32'h0, z, 1'b1, 1'b0);

      // RV32E, no M, 2-bit saturating counter
      b_issue("b mul", 32'h022081B3, 1'b0, ill(5'd1, 5'd2, 5'd3),
              1'b1, 2'd1);
      b_issue("b add_x17", 32'h002088B3, 1'b0, ill(5'd1, 5'd2, 5'd17),
              1'b1, 2'd2);
      b_issue("b add_x0", 32'h00208033, 1'b0, ok(4'd1, 4'h0, 3'd0, 5'd1,
              5'd2, 5'd0, 5'b11000, 3'b000, 32'h0), 1'b1, 2'd2);
      b_issue("b addi", 32'hFFF00093, 1'b0, ok(4'd2, 4'h0, 3'd0, 5'd0,
              5'd0, 5'd1, 5'b10100, 3'b000, 32'hFFFFFFFF), 1'b1, 2'd2);
      b_issue("b flush", 32'h00000000, 1'b1, z, 1'b0, 2'd2);
      b_issue("b ill3", 32'h00000000, 1'b0, ill(5'd0, 5'd0, 5'd0),
              1'b1, 2'd3);
      b_issue("b ill4", 32'h00000000, 1'b0, ill(5'd0, 5'd0, 5'd0),
              1'b1, 2'd3);
      b_issue("b ill5", 32'h00000000, 1'b0, ill(5'd0, 5'd0, 5'd0),
              1'b1, 2'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
